uctrl_seq: RTL and testbench
============================

UCTRL_SEQ -- requirements
Module: uctrl_seq

Interface
REQ-001 Parameter MEM_WAIT, default 2: memory read latency in cycles; legal range 0..15.
REQ-002 Parameter MD_TIMEOUT, default 40: maximum MD_RUN cycles before a timeout exception; legal range 1..255.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port opcode, input, 6 bits: IR[31:26].
REQ-006 Port funct, input, 6 bits: IR[5:0]; used only when opcode==0.
REQ-007 Ports eqf, gtf, ov, div0, input, 1 bit each: ALU equal/greater/overflow flags and divider zero-divisor flag.
REQ-008 Port md_done, input, 1 bit: mult/div unit result-valid pulse.
REQ-009 Strobe outputs, 1 bit each: pc_write, ir_write, mem_read, mem_write, reg_write, hilo_write, epc_write, md_start.
REQ-010 Port md_mode, output, 1 bit: 1=DIV, 0=MULT.
REQ-011 Port pc_src, output, 2 bits: 00 PC+4, 01 branch target, 10 jump target or exception vector, 11 rs (JR).
REQ-012 Port excp_code, output, 2 bits: 00 bad opcode, 01 overflow, 10 divide-by-zero, 11 mult/div timeout.
REQ-013 Port state_o, output, 4 bits: current state encoding, for debug.

Function
REQ-014 States SHALL be FETCH, DECODE, EXEC, MEM, WB, MD_RUN, HILO, BRANCH, EXCP, EXCP_RD, EXCP_JUMP; outputs SHALL be decoded from the registered state (Moore).
REQ-015 FETCH SHALL assert mem_read for MEM_WAIT+1 cycles and assert ir_write, pc_write and pc_src=00 in the last of those cycles, then go to DECODE.
REQ-016 DECODE SHALL last one cycle and go to EXEC.
REQ-017 EXEC dispatch: ADD/SUB/AND/SLT/SLL/SRL/SRA/SLLV/SRAV/ADDI/ADDIU/SLTI/LUI go to WB; LB/LH/LW/SB/SH/SW go to MEM; MULT/DIV assert md_start for one cycle (md_mode set) and go to MD_RUN; BEQ/BNE/BLE/BGT go to BRANCH if taken, else FETCH; J/JAL/JR go to BRANCH; any other code goes to EXCP with code 00.
REQ-018 Branch conditions: BEQ eqf; BNE !eqf; BGT gtf; BLE eqf|!gtf.
REQ-019 In EXEC, ov=1 on ADD, SUB or ADDI SHALL go to EXCP with code 01 and no reg_write; ov SHALL be ignored for all other instructions.
REQ-020 In EXEC, div0=1 on DIV SHALL go to EXCP with code 10 and no md_start.
REQ-021 MEM SHALL last MEM_WAIT+1 cycles: loads assert mem_read throughout, then go to WB; stores assert mem_write in the last cycle only, then go to FETCH.
REQ-022 WB SHALL assert reg_write for one cycle, then go to FETCH.
REQ-023 BRANCH SHALL assert pc_write for one cycle with pc_src 01 (conditional branches), 10 (J/JAL) or 11 (JR); JAL SHALL also assert reg_write. It then goes to FETCH.
REQ-024 MD_RUN SHALL count cycles from 1: md_done goes to HILO; otherwise, on count==MD_TIMEOUT it goes to EXCP with code 11; md_done in that same cycle SHALL win.
REQ-025 HILO SHALL assert hilo_write for one cycle, then go to FETCH.
REQ-026 EXCP SHALL assert epc_write for one cycle and latch excp_code, then go to EXCP_RD.
REQ-027 EXCP_RD SHALL assert mem_read for MEM_WAIT+1 cycles, then go to EXCP_JUMP.
REQ-028 EXCP_JUMP SHALL assert pc_write with pc_src=10, then go to FETCH.
REQ-029 excp_code SHALL hold its last latched value until the next exception.
REQ-030 Only one of mem_read and mem_write SHALL be high in any cycle.

Reset
REQ-031 reset low SHALL immediately force state FETCH, all strobes 0, pc_src 00, md_mode 0, excp_code 00 and all counters 0, in any state including MD_RUN and MEM.
REQ-032 The first FETCH cycle SHALL be the first rising clk edge after reset deasserts.

Structure
REQ-033 Package uctrl_pkg SHALL hold the state enum, opcode/funct constants, pc_src codes and excp_code codes.
REQ-034 A single wait-counter sub-module, uctrl_wait_cnt (load, decrement, zero flag), SHALL serve FETCH, MEM, EXCP_RD and MD_RUN.

Verification (MEM_WAIT=2, MD_TIMEOUT=40; cycle 0 = first FETCH cycle)
REQ-035 ADD (opcode 0, funct 0x20, ov=0) -> ir_write in cycle 2, reg_write in cycle 5, FETCH again in cycle 6.
REQ-036 LW (opcode 0x23) -> mem_read in cycles 0-2 and 5-7, reg_write in cycle 8; SW (0x2B) -> mem_write in cycle 7 only.
REQ-037 DIV with div0=1 -> no md_start, epc_write in cycle 5 with excp_code 10, pc_write with pc_src 10 in cycle 9.
REQ-038 MULT with md_done never asserted -> md_start in cycle 4, EXCP entered after 40 MD_RUN cycles with code 11; md_done in MD_RUN cycle 40 -> hilo_write instead.
REQ-039 BLE with eqf=0, gtf=1 -> not taken, back to FETCH in cycle 5; BNE with eqf=0 -> pc_write with pc_src 01 in cycle 5.
REQ-040 reset pulsed low during MD_RUN -> all outputs 0 immediately, then normal FETCH.

Source files
------------

// File: rtl/uctrl_pkg.sv
// Shared types and constants for the multi-cycle micro-sequencer: states, instruction
// classes, opcode/funct values, PC source and exception codes.
package uctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StMdRun,
    StHilo,
    StBranch,
    StExcp,
    StExcpRd,
    StExcpJump
  } state_e;

  typedef enum logic [3:0] {
    ClsAlu,
    ClsAluOv,
    ClsLoad,
    ClsStore,
    ClsMult,
    ClsDiv,
    ClsBeq,
    ClsBne,
    ClsBle,
    ClsBgt,
    ClsJ,
    ClsJal,
    ClsJr,
    ClsBad
  } instr_cls_e;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpBle     = 6'h06;
  localparam logic [5:0] OpBgt     = 6'h07;
  localparam logic [5:0] OpAddi    = 6'h08;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpSlti    = 6'h0a;
  localparam logic [5:0] OpLui     = 6'h0f;
  localparam logic [5:0] OpLb      = 6'h20;
  localparam logic [5:0] OpLh      = 6'h21;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpSb      = 6'h28;
  localparam logic [5:0] OpSh      = 6'h29;
  localparam logic [5:0] OpSw      = 6'h2b;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnSllv = 6'h04;
  localparam logic [5:0] FnSrav = 6'h07;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnMult = 6'h18;
  localparam logic [5:0] FnDiv  = 6'h1a;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnSlt  = 6'h2a;

  localparam logic [1:0] PcSrcSeq    = 2'b00;
  localparam logic [1:0] PcSrcBranch = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;
  localparam logic [1:0] PcSrcReg    = 2'b11;

  localparam logic [1:0] ExcpBadOp     = 2'b00;
  localparam logic [1:0] ExcpOverflow  = 2'b01;
  localparam logic [1:0] ExcpDivZero   = 2'b10;
  localparam logic [1:0] ExcpMdTimeout = 2'b11;

  // ClsAluOv marks the instructions whose overflow flag raises an exception.
  function automatic instr_cls_e decode_instr(input logic [5:0] op, input logic [5:0] fn);
    instr_cls_e cls;
    cls = ClsBad;
    case (op)
      OpSpecial: begin
        case (fn)
          FnAdd, FnSub:                                   cls = ClsAluOv;
          FnAnd, FnSlt, FnSll, FnSrl, FnSra, FnSllv, FnSrav: cls = ClsAlu;
          FnMult:                                         cls = ClsMult;
          FnDiv:                                          cls = ClsDiv;
          FnJr:                                           cls = ClsJr;
          default:                                        cls = ClsBad;
        endcase
      end
      OpAddi:                 cls = ClsAluOv;
      OpAddiu, OpSlti, OpLui: cls = ClsAlu;
      OpLb, OpLh, OpLw:       cls = ClsLoad;
      OpSb, OpSh, OpSw:       cls = ClsStore;
      OpBeq:                  cls = ClsBeq;
      OpBne:                  cls = ClsBne;
      OpBle:                  cls = ClsBle;
      OpBgt:                  cls = ClsBgt;
      OpJ:                    cls = ClsJ;
      OpJal:                  cls = ClsJal;
      default:                cls = ClsBad;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/uctrl_wait_cnt.sv
// Down-counter shared by all multi-cycle states: load a value, decrement to zero, flag zero.
module uctrl_wait_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uctrl_seq.sv
// Multi-cycle MIPS-style control sequencer: Moore strobes decoded from the registered state,
// with one shared wait counter timing fetch, memory, exception reads and mult/div timeout.
module uctrl_seq
  import uctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT   = 2,
  parameter int unsigned MD_TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       eqf,
  input  logic       gtf,
  input  logic       ov,
  input  logic       div0,
  input  logic       md_done,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       hilo_write,
  output logic       epc_write,
  output logic       md_start,
  output logic       md_mode,
  output logic [1:0] pc_src,
  output logic [1:0] excp_code,
  output logic [3:0] state_o
);

  state_e     state_q, state_d;
  instr_cls_e cls_q, cls_d;
  logic [1:0] excp_code_q, excp_code_d;
  // Low from reset until the first clock edge so that edge starts a full-length fetch.
  logic       run_q;
  logic       cnt_zero, cnt_load, cnt_dec;
  logic [7:0] cnt_val;

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    excp_code_d = excp_code_q;
    unique case (state_q)
      StFetch: if (cnt_zero) state_d = StDecode;
      StDecode: begin
        cls_d   = decode_instr(opcode, funct);
        state_d = StExec;
      end
      StExec: begin
        unique case (cls_q)
          ClsAlu: state_d = StWb;
          ClsAluOv: begin
            if (ov) begin
              state_d     = StExcp;
              excp_code_d = ExcpOverflow;
            end else begin
              state_d = StWb;
            end
          end
          ClsLoad, ClsStore: state_d = StMem;
          ClsMult:           state_d = StMdRun;
          ClsDiv: begin
            if (div0) begin
              state_d     = StExcp;
              excp_code_d = ExcpDivZero;
            end else begin
              state_d = StMdRun;
            end
          end
          ClsBeq:           state_d = eqf           ? StBranch : StFetch;
          ClsBne:           state_d = !eqf          ? StBranch : StFetch;
          ClsBle:           state_d = (eqf || !gtf) ? StBranch : StFetch;
          ClsBgt:           state_d = gtf           ? StBranch : StFetch;
          ClsJ, ClsJal, ClsJr: state_d = StBranch;
          default: begin
            state_d     = StExcp;
            excp_code_d = ExcpBadOp;
          end
        endcase
      end
      StMem: if (cnt_zero) state_d = (cls_q == ClsLoad) ? StWb : StFetch;
      StWb, StHilo, StBranch, StExcpJump: state_d = StFetch;
      StMdRun: begin
        // A result arriving on the timeout cycle still takes priority.
        if (md_done) begin
          state_d = StHilo;
        end else if (cnt_zero) begin
          state_d     = StExcp;
          excp_code_d = ExcpMdTimeout;
        end
      end
      StExcp:   state_d = StExcpRd;
      StExcpRd: if (cnt_zero) state_d = StExcpJump;
      default:  state_d = StFetch;
    endcase
    if (!run_q) begin
      state_d = StFetch;
    end
  end

  // Counter is loaded on entry to a timed state; MD_RUN cycle n sees MD_TIMEOUT-n.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = 8'(MEM_WAIT);
    if ((state_d != state_q) || !run_q) begin
      case (state_d)
        StFetch, StMem, StExcpRd: cnt_load = 1'b1;
        StMdRun: begin
          cnt_load = 1'b1;
          cnt_val  = 8'(MD_TIMEOUT - 1);
        end
        default: cnt_load = 1'b0;
      endcase
    end
    cnt_dec = !cnt_load;
  end

  uctrl_wait_cnt #(
    .Width(8)
  ) u_wait_cnt (
    .clk_i     (clk),
    .rst_ni    (reset),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StFetch;
      cls_q       <= ClsAlu;
      excp_code_q <= ExcpBadOp;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      excp_code_q <= excp_code_d;
      run_q       <= 1'b1;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    hilo_write = 1'b0;
    epc_write  = 1'b0;
    md_start   = 1'b0;
    md_mode    = 1'b0;
    pc_src     = PcSrcSeq;
    unique case (state_q)
      StFetch: begin
        mem_read = 1'b1;
        if (cnt_zero) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      StExec: begin
        md_start = (cls_q == ClsMult) || ((cls_q == ClsDiv) && !div0);
        md_mode  = (cls_q == ClsDiv);
      end
      StMem: begin
        mem_read  = (cls_q == ClsLoad);
        mem_write = (cls_q == ClsStore) && cnt_zero;
      end
      StWb:    reg_write = 1'b1;
      StMdRun: md_mode   = (cls_q == ClsDiv);
      StHilo: begin
        hilo_write = 1'b1;
        md_mode    = (cls_q == ClsDiv);
      end
      StBranch: begin
        pc_write = 1'b1;
        unique case (cls_q)
          ClsJ:    pc_src = PcSrcJump;
          ClsJal: begin
            pc_src    = PcSrcJump;
            reg_write = 1'b1;
          end
          ClsJr:   pc_src = PcSrcReg;
          default: pc_src = PcSrcBranch;
        endcase
      end
      StExcp:   epc_write = 1'b1;
      StExcpRd: mem_read  = 1'b1;
      StExcpJump: begin
        pc_write = 1'b1;
        pc_src   = PcSrcJump;
      end
      default: pc_write = 1'b0;
    endcase
    if (!run_q) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      hilo_write = 1'b0;
      epc_write  = 1'b0;
      md_start   = 1'b0;
      md_mode    = 1'b0;
      pc_src     = PcSrcSeq;
    end
  end

  assign excp_code = excp_code_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_uctrl_seq.sv
// Self-checking bench: builds an expected per-cycle strobe trace for each instruction from
// the sequencing rules, then drives the instruction and compares every cycle.
module tb_uctrl_seq;

  localparam int unsigned MW = 2;
  localparam int unsigned MT = 40;

  localparam logic [12:0] PW   = 13'h1000;
  localparam logic [12:0] IRW  = 13'h0800;
  localparam logic [12:0] MRD  = 13'h0400;
  localparam logic [12:0] MWR  = 13'h0200;
  localparam logic [12:0] RW   = 13'h0100;
  localparam logic [12:0] HW   = 13'h0080;
  localparam logic [12:0] EPW  = 13'h0040;
  localparam logic [12:0] MDS  = 13'h0020;
  localparam logic [12:0] MDM  = 13'h0010;
  localparam logic [12:0] SBR  = 13'h0004;
  localparam logic [12:0] SJ   = 13'h0008;
  localparam logic [12:0] SJR  = 13'h000c;

  localparam int K_ALU = 0, K_ALUOV = 1, K_LD = 2, K_ST = 3, K_MULT = 4, K_DIV = 5;
  localparam int K_BEQ = 6, K_BNE = 7, K_BLE = 8, K_BGT = 9, K_J = 10, K_JAL = 11;
  localparam int K_JR = 12, K_BAD = 13;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       eqf, gtf, ov, div0, md_done;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write, hilo_write, epc_write;
  logic       md_start, md_mode;
  logic [1:0] pc_src, excp_code;
  logic [3:0] state_o;

  uctrl_seq #(
    .MEM_WAIT  (MW),
    .MD_TIMEOUT(MT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .eqf       (eqf),
    .gtf       (gtf),
    .ov        (ov),
    .div0      (div0),
    .md_done   (md_done),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .hilo_write(hilo_write),
    .epc_write (epc_write),
    .md_start  (md_start),
    .md_mode   (md_mode),
    .pc_src    (pc_src),
    .excp_code (excp_code),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  wire [12:0] obs = {pc_write, ir_write, mem_read, mem_write, reg_write, hilo_write,
                     epc_write, md_start, md_mode, pc_src, excp_code};

  int          checks = 0;
  int          errors = 0;
  logic [12:0] exp_q[$];
  logic [12:0] msk_q[$];
  bit          done_q[$];
  logic [1:0]  cur_code;

  logic [5:0] rfn[12] = '{6'h20, 6'h22, 6'h24, 6'h2a, 6'h00, 6'h02, 6'h03, 6'h04, 6'h07,
                          6'h18, 6'h1a, 6'h08};
  logic [5:0] iop[16] = '{6'h08, 6'h09, 6'h0a, 6'h0f, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29,
                          6'h2b, 6'h04, 6'h05, 6'h06, 6'h07, 6'h02, 6'h03};
  logic [11:0] bad[4] = '{{6'h3f, 6'h00}, {6'h10, 6'h20}, {6'h00, 6'h3f}, {6'h00, 6'h01}};

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h22:                             return K_ALUOV;
        6'h24, 6'h2a, 6'h00, 6'h02, 6'h03, 6'h04, 6'h07: return K_ALU;
        6'h18:                                    return K_MULT;
        6'h1a:                                    return K_DIV;
        6'h08:                                    return K_JR;
        default:                                  return K_BAD;
      endcase
    end
    case (op)
      6'h08:               return K_ALUOV;
      6'h09, 6'h0a, 6'h0f: return K_ALU;
      6'h20, 6'h21, 6'h23: return K_LD;
      6'h28, 6'h29, 6'h2b: return K_ST;
      6'h04:               return K_BEQ;
      6'h05:               return K_BNE;
      6'h06:               return K_BLE;
      6'h07:               return K_BGT;
      6'h02:               return K_J;
      6'h03:               return K_JAL;
      default:             return K_BAD;
    endcase
  endfunction

  // md_mode is only required to be meaningful alongside md_start.
  task automatic push(input logic [12:0] bits, input bit drv);
    exp_q.push_back(bits | {11'b0, cur_code});
    msk_q.push_back((bits & MDS) != 0 ? 13'h1fff : 13'h1fef);
    done_q.push_back(drv);
  endtask

  task automatic push_excp(input logic [1:0] code);
    cur_code = code;
    push(EPW, 1'b0);
    for (int i = 0; i <= int'(MW); i++) push(MRD, 1'b0);
    push(PW | SJ, 1'b0);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input bit eq, input bit gt,
                       input bit ovf, input bit dz, input int done_k);
    int  kind;
    bit  ms;
    exp_q.delete();
    msk_q.delete();
    done_q.delete();
    for (int i = 0; i <= int'(MW); i++) push(i == int'(MW) ? (MRD | PW | IRW) : MRD, 1'b0);
    push(13'h0, 1'b0);
    kind = kind_of(op, fn);
    ms   = (kind == K_MULT) || (kind == K_DIV && !dz);
    push((ms ? MDS : 13'h0) | (kind == K_DIV ? MDM : 13'h0), 1'b0);
    case (kind)
      K_ALU:   push(RW, 1'b0);
      K_ALUOV: if (ovf) push_excp(2'b01); else push(RW, 1'b0);
      K_LD: begin
        for (int i = 0; i <= int'(MW); i++) push(MRD, 1'b0);
        push(RW, 1'b0);
      end
      K_ST: begin
        for (int i = 0; i < int'(MW); i++) push(13'h0, 1'b0);
        push(MWR, 1'b0);
      end
      K_MULT, K_DIV: begin
        if (kind == K_DIV && dz) begin
          push_excp(2'b10);
        end else begin
          for (int k = 1; k <= int'(MT) && k <= done_k; k++) push(13'h0, k == done_k);
          if (done_k <= int'(MT)) push(HW, 1'b0);
          else push_excp(2'b11);
        end
      end
      K_BEQ: if (eq) push(PW | SBR, 1'b0);
      K_BNE: if (!eq) push(PW | SBR, 1'b0);
      K_BLE: if (eq || !gt) push(PW | SBR, 1'b0);
      K_BGT: if (gt) push(PW | SBR, 1'b0);
      K_J:   push(PW | SJ, 1'b0);
      K_JAL: push(PW | SJ | RW, 1'b0);
      K_JR:  push(PW | SJR, 1'b0);
      default: push_excp(2'b00);
    endcase
  endtask

  task automatic check(input string tag, input logic [12:0] expv, input logic [12:0] msk);
    checks++;
    assert ((obs & msk) === (expv & msk))
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs & msk, expv & msk);
    end
  endtask

  // Runs one instruction from its first fetch cycle; abort >= 0 pulses reset mid-cycle there.
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input bit eq, input bit gt, input bit ovf, input bit dz, input int done_k,
                     input int abort);
    build(op, fn, eq, gt, ovf, dz, done_k);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        opcode = op;
        funct  = fn;
        eqf    = eq;
        gtf    = gt;
        ov     = ovf;
        div0   = dz;
      end
      md_done = done_q[i];
      if (i == abort) begin
        #2 reset = 1'b0;
        #1 check({tag, "_rst_async"}, 13'h0, 13'h1fff);
        @(posedge clk);
        #1 check({tag, "_rst_hold"}, 13'h0, 13'h1fff);
        @(negedge clk);
        reset    = 1'b1;
        md_done  = 1'b0;
        cur_code = 2'b00;
        return;
      end
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, i), exp_q[i], msk_q[i]);
    end
    md_done = 1'b0;
  endtask

  initial begin
    int         r;
    logic [5:0] op, fn;
    reset    = 1'b0;
    opcode   = '0;
    funct    = '0;
    eqf      = 1'b0;
    gtf      = 1'b0;
    ov       = 1'b0;
    div0     = 1'b0;
    md_done  = 1'b0;
    cur_code = 2'b00;
    repeat (3) begin
      @(negedge clk);
      check("reset", 13'h0, 13'h1fff);
    end
    reset = 1'b1;

    run("add",      6'h00, 6'h20, 0, 0, 0, 0, 99, -1);
    run("lw",       6'h23, 6'h00, 0, 0, 0, 0, 99, -1);
    run("sw",       6'h2b, 6'h00, 0, 0, 0, 0, 99, -1);
    run("div0",     6'h00, 6'h1a, 0, 0, 0, 1, 99, -1);
    run("mult_to",  6'h00, 6'h18, 0, 0, 0, 0, 99, -1);
    run("mult_d40", 6'h00, 6'h18, 0, 0, 0, 0, 40, -1);
    run("div_d3",   6'h00, 6'h1a, 0, 0, 0, 0, 3, -1);
    run("ble_nt",   6'h06, 6'h00, 0, 1, 0, 0, 99, -1);
    run("bne_t",    6'h05, 6'h00, 0, 0, 0, 0, 99, -1);
    run("add_ov",   6'h00, 6'h20, 0, 0, 1, 0, 99, -1);
    run("addiu_ov", 6'h09, 6'h00, 0, 0, 1, 0, 99, -1);
    run("badop",    6'h3f, 6'h00, 0, 0, 0, 0, 99, -1);
    run("jal",      6'h03, 6'h00, 0, 0, 0, 0, 99, -1);
    run("jr",       6'h00, 6'h08, 0, 0, 0, 0, 99, -1);
    run("rst_md",   6'h00, 6'h18, 0, 0, 0, 0, 99, int'(MW) + 8);
    run("post_md",  6'h00, 6'h20, 0, 0, 0, 0, 99, -1);
    run("rst_mem",  6'h23, 6'h00, 0, 0, 0, 0, 99, int'(MW) + 4);
    run("post_mem", 6'h2b, 6'h00, 0, 0, 0, 0, 99, -1);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 31);
      if (r < 12) begin
        op = 6'h00;
        fn = rfn[r];
      end else if (r < 28) begin
        op = iop[r-12];
        fn = 6'($urandom);
      end else begin
        op = bad[r-28][11:6];
        fn = bad[r-28][5:0];
      end
      run($sformatf("rnd%0d", n), op, fn, 1'($urandom), 1'($urandom),
          1'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(1, 45), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
